// File: rtl/ncl_seq_ripple_adder.sv
// Clocked dual-rail (NCL) ripple adder/subtractor: captures a complete DATA wavefront,
// resolves one result digit per clock, then holds until downstream requests NULL.
module ncl_seq_ripple_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               init_n,
  input  logic [2*WIDTH-1:0] a,
  input  logic [2*WIDTH-1:0] b,
  input  logic [1:0]         carryin,
  input  logic [1:0]         mode,
  input  logic               sumCOMP,
  output logic               ABCOMP,
  output logic [2*WIDTH-1:0] sum,
  output logic [1:0]         carryout,
  output logic               err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_NULL, S_RIPPLE, S_HOLD} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        idx, idx_n;
  logic [WIDTH-1:0]     op_a, op_a_n, op_b, op_b_n;
  logic                 carry, carry_n;
  logic [2*WIDTH-1:0]   sum_q, sum_n;
  logic [1:0]           cout_q, cout_n;
  logic                 abcomp_q, abcomp_n;
  logic                 err_q, err_n;

  logic                 in_data, in_null, in_ill;
  logic                 rip_s, rip_c;

  // An illegal digit (11) is neither DATA nor NULL, so it blocks both wavefronts.
  always_comb begin
    in_data = (^carryin) & (^mode);
    in_null = (carryin == 2'b00) & (mode == 2'b00);
    in_ill  = (&carryin) | (&mode);
    for (int i = 0; i < WIDTH; i++) begin
      in_data = in_data & (^a[2*i +: 2]) & (^b[2*i +: 2]);
      in_null = in_null & (a[2*i +: 2] == 2'b00) & (b[2*i +: 2] == 2'b00);
      in_ill  = in_ill | (&a[2*i +: 2]) | (&b[2*i +: 2]);
    end
  end

  assign rip_s = op_a[idx] ^ op_b[idx] ^ carry;
  assign rip_c = (op_a[idx] & op_b[idx]) | (carry & (op_a[idx] ^ op_b[idx]));

  // NOTE: every variable takes its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_n  = state;
    idx_n    = idx;
    op_a_n   = op_a;
    op_b_n   = op_b;
    carry_n  = carry;
    sum_n    = sum_q;
    cout_n   = cout_q;
    abcomp_n = abcomp_q;
    err_n    = err_q | in_ill;

    case (state)
      S_NULL: begin
        if (in_data && !sumCOMP) begin
          state_n  = S_RIPPLE;
          idx_n    = '0;
          for (int i = 0; i < WIDTH; i++) begin
            op_a_n[i] = a[2*i+1];
            op_b_n[i] = b[2*i+1] ^ mode[1];
          end
          carry_n  = carryin[1];
          abcomp_n = 1'b1;
        end
      end
      S_RIPPLE: begin
        sum_n[2*idx +: 2] = rip_s ? 2'b10 : 2'b01;
        carry_n           = rip_c;
        idx_n             = idx + 1'b1;
        if (idx == IW'(WIDTH - 1)) begin
          cout_n  = rip_c ? 2'b10 : 2'b01;
          idx_n   = '0;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (sumCOMP && in_null) begin
          state_n  = S_NULL;
          sum_n    = '0;
          cout_n   = 2'b00;
          abcomp_n = 1'b0;
        end
      end
      default: state_n = S_NULL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state    <= S_NULL;
      idx      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 2'b00;
      abcomp_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      op_a     <= op_a_n;
      op_b     <= op_b_n;
      carry    <= carry_n;
      sum_q    <= sum_n;
      cout_q   <= cout_n;
      abcomp_q <= abcomp_n;
      err_q    <= err_n;
    end
  end

  assign ABCOMP   = abcomp_q;
  assign sum      = sum_q;
  assign carryout = cout_q;
  assign err      = err_q;

endmodule
